// File: rtl/uart_core.sv
// uart_core: parameterised UART transmitter and receiver with internal loopback.
// TX bit timing restarts at each accepted byte; RX samples on a 1/RX_OVERSAMPLE-bit tick.
module uart_core #(
    parameter int unsigned CLOCK_RATE    = 3200000,
    parameter int unsigned BAUD_RATE     = 100000,
    parameter int unsigned RX_OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_Loopback,
    input  logic                 i_Tx_Valid,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Data,
    input  logic                 i_Rx_Data,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Frame_Err
);
    localparam int unsigned RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
    localparam int unsigned TX_DIV = RX_DIV * RX_OVERSAMPLE;
    localparam int unsigned DIV_W  = $clog2(RX_DIV + 1);
    localparam int unsigned TXC_W  = $clog2(TX_DIV + 1);
    localparam int unsigned OS_W   = $clog2(RX_OVERSAMPLE + 1);
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    logic [DIV_W-1:0]     div_q, div_d;
    state_e               tx_state_q, tx_state_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;
    logic [1:0]           sync_q, sync_d;
    state_e               rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_armed_q, rx_armed_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;

    logic rx_tick_c, tx_tick_c, rx_s_c, rx_samp_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            sync_q     <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_armed_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_armed_q <= rx_armed_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // TX next state; the line register follows the state being entered
    always_comb begin
        div_d      = (div_q == DIV_W'(RX_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        tx_tick_c  = (tx_cnt_q == TXC_W'(TX_DIV - 1));
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick_c ? '0 : tx_cnt_q + TXC_W'(1);
        case (tx_state_q)
            S_IDLE: if (i_Tx_Valid) begin
                tx_state_d = S_START;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_shift_d = i_Tx_Byte;
                tx_par_d   = (PARITY == 1) ? ~^i_Tx_Byte : ^i_Tx_Byte;
            end
            S_START: if (tx_tick_c) tx_state_d = S_DATA;
            S_DATA: if (tx_tick_c) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                    tx_bit_d   = '0;
                    tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + BIT_W'(1);
                end
            end
            S_PARITY: if (tx_tick_c) tx_state_d = S_STOP;
            S_STOP: if (tx_tick_c) begin
                if (tx_bit_q == BIT_W'(STOP_BITS - 1)) begin
                    tx_bit_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + BIT_W'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = tx_shift_d[0];
            S_PARITY: tx_line_d = tx_par_d;
            default:  tx_line_d = 1'b1;
        endcase
    end

    // RX next state; a break keeps the receiver disarmed until the line is seen high
    always_comb begin
        rx_tick_c  = (div_q == DIV_W'(RX_DIV - 1));
        sync_d     = {sync_q[0], i_Loopback ? tx_line_q : i_Rx_Data};
        rx_s_c     = sync_q[1];
        rx_samp_c  = rx_tick_c && (rx_cnt_q == OS_W'(RX_OVERSAMPLE - 1));
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_armed_d = rx_armed_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        if (rx_tick_c) rx_cnt_d = rx_cnt_q + OS_W'(1);
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s_c) rx_armed_d = 1'b1;
                else if (rx_armed_q) rx_state_d = S_START;
            end
            S_START: if (rx_tick_c && rx_cnt_q == OS_W'(RX_OVERSAMPLE / 2 - 1)) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s_c ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_samp_c) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s_c, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                    rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + BIT_W'(1);
                end
            end
            S_PARITY: if (rx_samp_c) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_s_c;
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_samp_c) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
                rx_armed_d = 1'b0;
                rx_valid_d = 1'b1;
                rx_byte_d  = rx_shift_q;
                rx_ferr_d  = ~rx_s_c;
                case (PARITY)
                    1:       rx_perr_d = ~^{rx_shift_q, rx_par_q};
                    2:       rx_perr_d = ^{rx_shift_q, rx_par_q};
                    default: rx_perr_d = 1'b0;
                endcase
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Tx_Ready      = (tx_state_q == S_IDLE);
        o_Tx_Active     = (tx_state_q != S_IDLE);
        o_Tx_Data       = i_Loopback | tx_line_q;
        o_Rx_Valid      = rx_valid_q;
        o_Rx_Byte       = rx_byte_q;
        o_Rx_Parity_Err = rx_perr_q;
        o_Rx_Frame_Err  = rx_ferr_q;
    end
endmodule
